// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrating output multiplexer.
package arb_mux_pkg;

    // Arbitration mode encoding carried on the mode input.
    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

endpackage : arb_mux_pkg

// File: rtl/arb_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr (with wrap)
// and advances ptr past the winner whenever the grant is consumed.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         ld,
    output logic [N-1:0] grant
);

    logic [SW-1:0] ptr_q;
    logic [SW-1:0] ptr_d;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] idx;
    logic [SW:0]   sum;
    logic          found;

    // Search upward from ptr with wrap; first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (SW+1)'(k);
            if (sum >= (SW+1)'(N)) begin
                sum = sum - (SW+1)'(N);
            end
            idx = sum[SW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Pointer moves to the channel after the winner, only on a consumed grant.
    always_comb begin
        ptr_d = ptr_q;
        if (ld && found) begin
            ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
        end
    end

    // Pointer register; reset gives channel 0 top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/arb_mux.sv
// N-channel valid/ready multiplexer with explicit-select or round-robin
// arbitration feeding a single registered output stage (1 word/cycle).
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 3,
    parameter int unsigned SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      select,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_chan,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    logic [N-1:0]     sel_grant;
    logic [N-1:0]     rr_grant;
    logic [N-1:0]     rr_req;
    logic [N-1:0]     grant;
    logic             ld;
    logic             take;
    logic [WIDTH-1:0] mux_data;
    logic [SW-1:0]    mux_chan;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    // Explicit-select decode; an out-of-range select matches no channel.
    always_comb begin
        sel_err   = (mode == MODE_SEL) && ({1'b0, select} >= (SW+1)'(N));
        sel_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (select == SW'(i)) begin
                sel_grant[i] = in_valid[i];
            end
        end
    end

    // The arbiter only sees requests in round-robin mode, so ptr freezes otherwise.
    assign rr_req = (mode == MODE_RR) ? in_valid : '0;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (rr_req),
        .ld    (ld),
        .grant (rr_grant)
    );

    // Handshake: the output stage loads when empty or draining this cycle.
    always_comb begin
        grant    = (mode == MODE_RR) ? rr_grant : sel_grant;
        ld       = !out_valid_q || out_ready;
        in_ready = reset ? '0 : (grant & {N{ld}});
        take     = |(in_ready & in_valid);
    end

    // Data/channel mux driven by the one-hot grant.
    always_comb begin
        mux_data = '0;
        mux_chan = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
                mux_chan = SW'(i);
            end
        end
    end

    // Output stage next state: load on input transfer, empty on drain.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (take) begin
            out_data_d  = mux_data;
            out_chan_d  = mux_chan;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule : arb_mux

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed vector table, hand-written
// round-robin/backpressure sequences, then randomized traffic against a model.
module tb_arb_mux;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 3;
    localparam int unsigned SW    = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SW-1:0]      select;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_chan;
    logic               out_valid;
    logic               out_ready;
    logic               sel_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_ov;
    logic [7:0] m_od;
    int         m_oc;
    int         m_ptr;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(WIDTH), .N(N), .SW(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .select    (select),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Winning channel by the arbitration rules, -1 if none.
    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(select) < N && in_valid[select]) return int'(select);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock: check combinational outputs, clock, update model, check registers.
    // Called just after a falling edge with inputs already driven; returns at the next one.
    task automatic step(input string tag);
        int         g;
        logic       ld;
        logic [N-1:0] er;
        logic       ee;
        #1;
        ld = !m_ov || out_ready;
        g  = model_grant();
        er = '0;
        if (!reset && ld && g >= 0) er[g] = 1'b1;
        ee = (mode == 1'b0) && (int'(select) >= N);
        check({tag, " in_ready"}, 32'(in_ready), 32'(er));
        check({tag, " sel_err"}, 32'(sel_err), 32'(ee));
        @(posedge clk);
        if (reset) begin
            m_ov = 1'b0; m_od = '0; m_oc = 0; m_ptr = 0;
        end else if (er != '0) begin
            m_ov = 1'b1;
            m_od = in_data[g*WIDTH +: WIDTH];
            m_oc = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, " out_data"}, 32'(out_data), 32'(m_od));
        check({tag, " out_chan"}, 32'(out_chan), 32'(m_oc));
        @(negedge clk);
    endtask

    typedef struct {
        logic         rst;
        logic         md;
        logic [1:0]   sel;
        logic [2:0]   vld;
        logic         ordy;
        logic [2:0]   e_rdy;
        logic         e_err;
        logic         e_ov;
        logic [7:0]   e_od;
        logic [1:0]   e_oc;
    } vec_t;

    vec_t vecs[15];
    logic [7:0] held_d;
    logic [1:0] held_c;

    initial begin
        // rst md sel vld ordy | rdy err | ov od oc
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 1'b0, 1'b1, 8'h22, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b1, 1'b0, 8'h22, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b1, 1'b0, 8'h22, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 3'b011, 1'b0, 3'b000, 1'b0, 1'b0, 8'h22, 2'd1};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 3'b001, 1'b0, 3'b001, 1'b0, 1'b1, 8'h11, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 2'd1, 3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 8'h11, 2'd0};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b0, 1'b1, 8'h11, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1'b0, 1'b1, 8'h22, 2'd1};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 3'b101, 1'b1, 3'b100, 1'b0, 1'b1, 8'h33, 2'd2};
        vecs[11] = '{1'b0, 1'b1, 2'd0, 3'b110, 1'b1, 3'b010, 1'b0, 1'b1, 8'h22, 2'd1};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 3'b011, 1'b1, 3'b001, 1'b0, 1'b1, 8'h11, 2'd0};
        vecs[13] = '{1'b1, 1'b1, 2'd0, 3'b101, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 2'd0};
        vecs[14] = '{1'b0, 1'b1, 2'd0, 3'b101, 1'b0, 3'b001, 1'b0, 1'b1, 8'h11, 2'd0};

        reset = 1'b1; mode = 1'b0; select = '0; in_valid = '0;
        in_data = {8'h33, 8'h22, 8'h11}; out_ready = 1'b1;
        m_ov = 1'b0; m_od = '0; m_oc = 0; m_ptr = 0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst; mode = vecs[i].md; select = vecs[i].sel;
            in_valid = vecs[i].vld; out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d rdy", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d err", i), 32'(sel_err), 32'(vecs[i].e_err));
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d ov", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d od", i), 32'(out_data), 32'(vecs[i].e_od));
            check($sformatf("vec%0d oc", i), 32'(out_chan), 32'(vecs[i].e_oc));
        end

        // Round-robin at full throughput from a fresh reset
        reset = 1'b1; step("rst2");
        reset = 1'b0; mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = N*WIDTH'($urandom);
            step($sformatf("rr%0d", i));
            check($sformatf("rr%0d chan", i), 32'(out_chan), 32'(i % 3));
            check($sformatf("rr%0d valid", i), 32'(out_valid), 32'd1);
        end

        // Backpressure: word held, no input accepted
        held_d = out_data; held_c = out_chan;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = N*WIDTH'($urandom);
            #1;
            check($sformatf("bp%0d rdy", i), 32'(in_ready), 32'd0);
            step($sformatf("bp%0d", i));
            check($sformatf("bp%0d hold data", i), 32'(out_data), 32'(held_d));
            check($sformatf("bp%0d hold chan", i), 32'(out_chan), 32'(held_c));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = N*WIDTH'($urandom);
            step($sformatf("bpr%0d", i));
            check($sformatf("bpr%0d chan", i), 32'(out_chan), 32'(i));
            check($sformatf("bpr%0d valid", i), 32'(out_valid), 32'd1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom);
            select    = 2'($urandom_range(0, 3));
            in_valid  = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = N*WIDTH'($urandom);
            step($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_arb_mux

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each data channel.
REQ-002 Parameter N, default 3, number of input channels; legal range 2..16.
REQ-003 Parameter SW, default $clog2(N), width of the select and channel-ID fields.
REQ-004 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  per-channel valid.
REQ-009 in_ready  output  N  per-channel ready; combinational.
REQ-010 mode  input  1  arbitration mode: 0 = explicit select, 1 = round-robin.
REQ-011 select  input  SW  channel index used when mode=0.
REQ-012 out_data  output  WIDTH  registered output data.
REQ-013 out_chan  output  SW  registered index of the channel that supplied out_data.
REQ-014 out_valid  output  1  registered output valid.
REQ-015 out_ready  input  1  downstream ready.
REQ-016 sel_err  output  1  combinational; high when mode=0 and select>=N.

Function
REQ-017 Output transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-018 Load-enable ld = !out_valid | out_ready; the output stage accepts a new word only when ld=1.
REQ-019 Input transfer on channel i occurs when in_valid[i]=1, grant[i]=1 and ld=1; in_ready[i] = grant[i] & ld.
REQ-020 grant is one-hot or zero; at most one in_ready bit is high in any cycle.
REQ-021 mode=0: grant[select] = in_valid[select] when select<N; when select>=N, grant=0, in_ready=0, sel_err=1, and no word is loaded.
REQ-022 mode=1: grant goes to the first valid channel, searching upward with wrap from priority pointer ptr.
REQ-023 After an input transfer from channel g in mode=1, ptr <= (g+1) mod N; otherwise ptr holds.
REQ-024 ptr does not update in mode=0.
REQ-025 On an input transfer, out_data, out_chan and out_valid (set to 1) load at the next edge; latency is 1 cycle.
REQ-026 On an output transfer with no simultaneous input transfer, out_valid <= 0 and out_data/out_chan hold.
REQ-027 Simultaneous output and input transfer: the new word replaces the old one and out_valid stays 1, giving full throughput of 1 word/cycle.
REQ-028 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold and all in_ready bits are 0.
REQ-029 A mode or select change takes effect on the same cycle's grant; a held output word is unaffected.
REQ-030 No X values are driven on any output under any select value.

Reset
REQ-031 While reset=1 at an edge: out_valid<=0, out_data<=0, out_chan<=0, ptr<=0.
REQ-032 During reset, in_ready is forced to 0, and any word pending mid-operation is discarded.
REQ-033 After reset, channel 0 has the highest round-robin priority.

Structure
REQ-034 A shared package holds the mode encoding constants (MODE_SEL=0, MODE_RR=1).
REQ-035 Round-robin grant logic and ptr are implemented in sub-module rr_arbiter #(N) (req, ld, grant, ptr state).
REQ-036 The output register stage stays in arb_mux.

Verification
REQ-037 Reset then idle: out_valid=0, out_data=0, out_chan=0, in_ready=0 while in_valid=0.
REQ-038 mode=0, select=1, in_valid=3'b111, data {C,B,A}={0x33,0x22,0x11}, out_ready=1: in_ready=3'b010; next cycle out_data=0x22, out_chan=1.
REQ-039 mode=0, select=3 (N=3): sel_err=1, in_ready=0, out_valid stays 0.
REQ-040 mode=1, all channels valid, out_ready=1 for 6 cycles: out_chan sequence 0,1,2,0,1,2 with out_valid continuously 1.
REQ-041 Backpressure: out_ready=0 for 3 cycles with a word held: out_data and out_chan stable, in_ready=0, ptr unchanged; then 1 word/cycle once out_ready=1.
REQ-042 Reset asserted while out_valid=1 and in_valid=3'b101: next cycle out_valid=0 and ptr=0; the first grant after reset goes to channel 0.
